uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
//
// PURPOSE
//   Sequences the receive-side baud rate generator and assembles UART frames.
//   Detects the start bit on the synchronised rx line, enables the generator via band_sig,
//   and samples each bit on the generator's mid-bit clk_bps pulse (first pulse = mid start bit).
//   Delivers the received bytes to the downstream logic through a valid/ready handshake.
//   Sits between the pad-level rx input / baud generator and the receive-side consumer.
//
// PARAMETERS
//   DATA_BITS   8   data bits per frame, LSB first (legal 5..8)
//   PARITY_ODD  0   parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd
//
// PORTS
//   clk          in   1          system clock
//   rst_n        in   1          asynchronous active-low reset
//   rx           in   1          raw serial input, idle high, asynchronous to clk
//   clk_bps      in   1          1-cycle mid-bit sample pulse from the baud generator
//   band_sig     out  1          baud generator enable; low = generator held at half-count preload
//   rx_data      out  DATA_BITS  received byte, stable while rx_valid=1
//   rx_valid     out  1          byte available
//   rx_ready     in   1          consumer accepts the byte when rx_valid & rx_ready
//   busy         out  1          frame in progress (state != IDLE)
//   frame_err    out  1          1-cycle pulse: stop bit sampled low
//   parity_err   out  1          1-cycle pulse: parity mismatch (tied 0 without the macro)
//   overrun_err  out  1          1-cycle pulse: completed byte dropped because the output was full
//
// BEHAVIOUR
//   - Reset values: band_sig=0, rx_data=0, rx_valid=0, busy=0, all error pulses 0,
//     rx sync flops=1, state=IDLE, bit_cnt=0.
//   - rx passes through a 2-FF synchroniser plus one history flop. Start = history 1, sync 0.
//     Start is detected only in IDLE.
//   - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. All transitions are registered.
//     * IDLE: band_sig=0. clk_bps is ignored. On start detect -> START and band_sig=1 next cycle.
//     * START: on clk_bps, if the synced rx is 1 (false start/glitch) -> IDLE with band_sig=0
//       and no error. Otherwise -> DATA with bit_cnt=0.
//     * DATA: on each clk_bps, shift the synced rx into shreg[DATA_BITS-1] (LSB first) and
//       increment bit_cnt. When bit_cnt = DATA_BITS-1 is sampled -> PARITY if the macro is
//       defined, else -> STOP.
//     * STOP: on clk_bps, classify the frame (see below) -> IDLE and band_sig=0 in the same update.
//       The generator then reloads HALF count.
//   - Stop classification:
//     * rx=1 and no parity error: the frame is good.
//     * rx=0: frame_err pulses and the byte is discarded.
//     * Parity error with a good stop: parity_err pulses and the byte is discarded.
//   - Output register: a good frame loads rx_data and sets rx_valid on the cycle after the
//     STOP clk_bps. rx_valid stays high until the cycle after rx_valid & rx_ready.
//   - Overrun: a good frame completes while rx_valid=1 and rx_ready=0. overrun_err pulses,
//     the new byte is dropped, and the old byte/valid are untouched.
//   - Simultaneous accept and completion (rx_valid & rx_ready in the completion cycle): the new
//     byte is loaded, rx_valid stays 1, and there is no overrun.
//   - clk_bps while band_sig=0 has no effect.
//   - rx low held permanently after IDLE (break) does not retrigger; a new 1->0 edge is required.
//   - Reset asserted mid-frame returns everything to its reset values immediately.
//     The partial byte is lost and no error is flagged.
//
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - Adds the PARITY state; the parity bit is sampled on one extra clk_bps.
//     - Expected parity = ^shreg ^ PARITY_ODD. A mismatch is recorded and reported at STOP.
//   UART_RX_PARITY_EN undefined:
//     - No PARITY state; the frame is 1 start + DATA_BITS + 1 stop.
//     - parity_err is driven constant 0.
//
// TESTING (bench drives clk_bps as 1-cycle pulses, >=16 clk apart; DATA_BITS=8)
//   1. Reset release, rx=1, no pulses -> band_sig=0, rx_valid=0, busy=0 for 100 cycles.
//   2. Frame 0xA5 with good stop, rx_ready=1 -> rx_data=0xA5, rx_valid high for 1 cycle,
//      band_sig=0 after STOP.
//   3. rx low for 3 cycles, then high before the first clk_bps -> return to IDLE,
//      rx_valid=0, no error pulse.
//   4. Frame 0x3C with stop bit 0 -> frame_err pulses once, rx_valid stays 0.
//   5. rx_ready=0; frames 0x11 then 0x22 -> rx_data=0x11 held, overrun_err pulses at the 0x22
//      stop. Raising rx_ready on the 0x22 completion cycle instead gives rx_data=0x22, no overrun.
//   6. UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> accepted;
//      with parity bit 0 -> parity_err pulses and rx_valid=0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, baud generator enable, frame assembly (parity via UART_RX_PARITY_EN).
// Latency: byte/error pulse registered on the cycle after the stop-bit clk_bps pulse.
// Backpressure: single-entry output register; a good frame arriving while full is dropped and flagged.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 clk_bps,
  output logic                 band_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_s1, rx_s2, rx_h;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic                 par_bad;
  logic                 frame_done;
  logic                 frame_good;

  // Two-flop synchroniser plus history flop; a falling edge is history=1, sync=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_h  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_h  <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (rx_h && !rx_s2) state_nxt = START;
      START:  if (clk_bps) state_nxt = rx_s2 ? IDLE : DATA;
      DATA: begin
        if (clk_bps && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: if (clk_bps) state_nxt = STOP;
      STOP: begin
        if (clk_bps) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The generator runs exactly while a frame is in progress.
  assign band_sig   = (state != IDLE);
  assign busy       = (state != IDLE);
  assign frame_good = frame_done && rx_s2 && !par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      par_bad     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= frame_done && !rx_s2;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= frame_done && rx_s2 && par_bad;
`endif
      if (state == START && clk_bps) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end
      if (state == DATA && clk_bps) begin
        shreg   <= {rx_s2, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == PARITY && clk_bps)
        par_bad <= rx_s2 ^ (^shreg) ^ PARITY_ODD;

      // A same-cycle accept frees the register, so the new byte replaces the old one.
      if (frame_good && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else begin
        if (frame_good)           overrun_err <= 1'b1;
        if (rx_valid && rx_ready) rx_valid    <= 1'b0;
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised and directed frame checks of uart_rx_ctrl against a frame-level model.
module tb_uart_rx_ctrl;

  localparam bit PAR_ODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       clk_bps;
  logic       rx_ready;
  logic       band_sig;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] got_q[$];
  int valid_cyc = 0;
  int fe_cnt    = 0;
  int pe_cnt    = 0;
  int ov_cnt    = 0;

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_ODD(PAR_ODD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .clk_bps    (clk_bps),
    .band_sig   (band_sig),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // Observer: records handshakes and pulse counts, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid)    valid_cyc = valid_cyc + 1;
      if (frame_err)   fe_cnt = fe_cnt + 1;
      if (parity_err)  pe_cnt = pe_cnt + 1;
      if (overrun_err) ov_cnt = ov_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic rdy_on_pulse);
    rx = b;
    tick(8);
    clk_bps = 1'b1;
    if (rdy_on_pulse) rx_ready = 1'b1;
    tick(1);
    clk_bps = 1'b0;
    if (rdy_on_pulse) rx_ready = 1'b0;
    tick(7);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                            input logic rdy_on_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
`ifdef UART_RX_PARITY_EN
    send_bit(1'(($countones(d) % 2) != 0) ^ PAR_ODD ^ par_flip, 1'b0);
`else
    if (par_flip) rx = 1'b1;
`endif
    send_bit(stop, rdy_on_stop);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1; clk_bps = 1'b0; rx_ready = 1'b0;
    tick(3);
    tests++;
    if ({band_sig, rx_valid, busy, frame_err, parity_err, overrun_err, rx_data} !== 14'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 0",
               {band_sig, rx_valid, busy, frame_err, parity_err, overrun_err, rx_data});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      tests++;
      if ({band_sig, rx_valid, busy} !== 3'b000) begin
        fails++;
        $display("FAIL idle_cycle%0d: band/valid/busy=%b required 000", c, {band_sig, rx_valid, busy});
      end
    end
    // Baud pulses while the generator is disabled must be ignored.
    for (int c = 0; c < 3; c++) begin
      clk_bps = 1'b1; tick(1); clk_bps = 1'b0; tick(15);
    end
    tests++;
    if ({busy, rx_valid, frame_err} !== 3'b000) begin
      fails++;
      $display("FAIL idle_bps: busy/valid/ferr=%b required 000", {busy, rx_valid, frame_err});
    end
  endtask

  task automatic test_good_frame;
    int n0, v0, f0, p0, o0;
    n0 = got_q.size(); v0 = valid_cyc; f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    tick(2);
    tests++;
    if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 8'hA5) begin
      fails++;
      $display("FAIL good_data: %0d bytes, last %h; required 1 byte A5", got_q.size() - n0,
               got_q.size() > 0 ? got_q[got_q.size()-1] : 8'h00);
    end
    tests++;
    if (valid_cyc - v0 != 1) begin
      fails++;
      $display("FAIL good_valid_len: %0d cycles required 1", valid_cyc - v0);
    end
    tests++;
    if ({band_sig, busy, rx_valid} !== 3'b000) begin
      fails++;
      $display("FAIL good_after_stop: band/busy/valid=%b required 000", {band_sig, busy, rx_valid});
    end
    tests++;
    if (fe_cnt != f0 || pe_cnt != p0 || ov_cnt != o0) begin
      fails++;
      $display("FAIL good_no_err: f/p/o deltas %0d/%0d/%0d required 0", fe_cnt - f0, pe_cnt - p0, ov_cnt - o0);
    end
  endtask

  task automatic test_false_start;
    int v0, f0, p0, o0;
    v0 = valid_cyc; f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
    rx = 1'b0;
    tick(3);
    tests++;
    if ({busy, band_sig} !== 2'b11) begin
      fails++;
      $display("FAIL glitch_start_seen: busy/band=%b required 11", {busy, band_sig});
    end
    rx = 1'b1;
    tick(5);
    clk_bps = 1'b1; tick(1); clk_bps = 1'b0;
    tick(3);
    tests++;
    if ({busy, band_sig, rx_valid} !== 3'b000) begin
      fails++;
      $display("FAIL glitch_return: busy/band/valid=%b required 000", {busy, band_sig, rx_valid});
    end
    tests++;
    if (valid_cyc != v0 || fe_cnt != f0 || pe_cnt != p0 || ov_cnt != o0) begin
      fails++;
      $display("FAIL glitch_no_event: valid/f/p/o deltas %0d/%0d/%0d/%0d required 0",
               valid_cyc - v0, fe_cnt - f0, pe_cnt - p0, ov_cnt - o0);
    end
  endtask

  task automatic test_frame_err;
    int n0, v0, f0;
    n0 = got_q.size(); v0 = valid_cyc; f0 = fe_cnt;
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    // rx stays low (break): no new frame may start.
    for (int c = 0; c < 40; c++) begin
      tick(1);
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL break_retrigger cycle%0d: busy=%b required 0", c, busy);
      end
    end
    rx = 1'b1;
    tick(5);
    tests++;
    if (fe_cnt - f0 != 1) begin
      fails++;
      $display("FAIL frame_err_count: %0d required 1", fe_cnt - f0);
    end
    tests++;
    if (valid_cyc != v0 || got_q.size() != n0) begin
      fails++;
      $display("FAIL frame_err_dropped: valid cycles %0d bytes %0d required 0/0",
               valid_cyc - v0, got_q.size() - n0);
    end
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    tick(2);
    tests++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      fails++;
      $display("FAIL overrun_hold: valid=%b data=%h required 1/11", rx_valid, rx_data);
    end
    tests++;
    if (ov_cnt - o0 != 1) begin
      fails++;
      $display("FAIL overrun_count: %0d required 1", ov_cnt - o0);
    end
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    tests++;
    if (got_q[got_q.size()-1] !== 8'h11 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL overrun_drain: got %h valid=%b required 11/0", got_q[got_q.size()-1], rx_valid);
    end

    o0 = ov_cnt;
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b1);
    tick(2);
    tests++;
    if (ov_cnt != o0 || rx_data !== 8'h44 || rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL simul_accept: ovr=%0d data=%h valid=%b required 0/44/1", ov_cnt - o0, rx_data, rx_valid);
    end
    tests++;
    if (got_q[got_q.size()-1] !== 8'h33) begin
      fails++;
      $display("FAIL simul_accept_old: got %h required 33", got_q[got_q.size()-1]);
    end
    rx_ready = 1'b1; tick(1);
    tests++;
    if (got_q[got_q.size()-1] !== 8'h44) begin
      fails++;
      $display("FAIL simul_drain: got %h required 44", got_q[got_q.size()-1]);
    end
  endtask

  task automatic test_reset_mid;
    int n0, f0;
    rx_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL midreset_busy_before: %b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({band_sig, rx_valid, busy, frame_err, overrun_err, rx_data} !== 13'h0) begin
      fails++;
      $display("FAIL midreset_async: %b required 0", {band_sig, rx_valid, busy, frame_err, overrun_err, rx_data});
    end
    tick(2);
    rst_n = 1'b1;
    rx = 1'b1;
    n0 = got_q.size(); f0 = fe_cnt;
    tick(20);
    tests++;
    if (busy !== 1'b0 || fe_cnt != f0) begin
      fails++;
      $display("FAIL midreset_quiet: busy=%b ferr=%0d required 0/0", busy, fe_cnt - f0);
    end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    tick(2);
    tests++;
    if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 8'h5A) begin
      fails++;
      $display("FAIL midreset_recover: %0d bytes required 1 byte 5A", got_q.size() - n0);
    end
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int n0, v0, p0;
    rx_ready = 1'b1;
    n0 = got_q.size(); p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    tick(2);
    tests++;
    if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 8'h07 || pe_cnt != p0) begin
      fails++;
      $display("FAIL parity_good: bytes %0d perr %0d required 1 byte 07, 0 perr", got_q.size() - n0, pe_cnt - p0);
    end
    n0 = got_q.size(); v0 = valid_cyc; p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    tick(2);
    tests++;
    if (pe_cnt - p0 != 1 || valid_cyc != v0 || got_q.size() != n0) begin
      fails++;
      $display("FAIL parity_bad: perr %0d valid %0d bytes %0d required 1/0/0",
               pe_cnt - p0, valid_cyc - v0, got_q.size() - n0);
    end
`else
    tests++;
    if (pe_cnt != 0 || parity_err !== 1'b0) begin
      fails++;
      $display("FAIL parity_tied: count %0d now %b required 0/0", pe_cnt, parity_err);
    end
`endif
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       stop, flip;
    int n0, f0, p0, o0, exp_f, exp_p;
    n0 = got_q.size(); f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
    exp_f = 0; exp_p = 0;
    rx_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 3) == 0);
`else
      flip = 1'b0;
`endif
      if (!stop)     exp_f++;
      else if (flip) exp_p++;
      else           exp_q.push_back(d);
      send_frame(d, stop, flip, 1'b0);
      rx = 1'b1;
      tick($urandom_range(2, 10));
    end
    tests++;
    if (got_q.size() - n0 != exp_q.size()) begin
      fails++;
      $display("FAIL rand_count: %0d bytes required %0d", got_q.size() - n0, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        tests++;
        if (got_q[n0 + k] !== exp_q[k]) begin
          fails++;
          $display("FAIL rand_byte%0d: got %h required %h", k, got_q[n0 + k], exp_q[k]);
        end
      end
    end
    tests++;
    if (fe_cnt - f0 != exp_f || pe_cnt - p0 != exp_p || ov_cnt != o0) begin
      fails++;
      $display("FAIL rand_errs: f/p/o %0d/%0d/%0d required %0d/%0d/0",
               fe_cnt - f0, pe_cnt - p0, ov_cnt - o0, exp_f, exp_p);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_parity();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
